// File: rtl/mheaa_acc_pkg.sv
// Shared types for the approximate column accumulator, plus a plain-arithmetic
// model of the approximate adder used by the scoreboard.
package mheaa_acc_pkg;

    typedef enum logic [1:0] {StIdle, StAccum, StHold} acc_state_e;

    localparam int unsigned RefMaxWidth = 64;

    // a and b must already be confined to len bits; bit len of the result is the carry-out.
    function automatic logic [RefMaxWidth:0] mheaa_ref_add(input logic [RefMaxWidth-1:0] a,
                                                          input logic [RefMaxWidth-1:0] b,
                                                          input int unsigned len,
                                                          input int unsigned imp);
        logic [RefMaxWidth:0] res;
        logic [RefMaxWidth:0] hi;
        logic                 carry;
        res = '0;
        for (int unsigned i = 0; i + 2 < imp; i++) begin
            res[i] = 1'b1;
        end
        res[imp-2] = a[imp-2] | b[imp-2];
        carry      = a[imp-1] | b[imp-1];
        hi         = ({1'b0, a} >> imp) + ({1'b0, b} >> imp) + {{RefMaxWidth{1'b0}}, carry};
        res        = res | (hi << imp);
        if (len < RefMaxWidth) begin
            res = res & ((65'd1 << (len + 1)) - 65'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/mheaa_adder.sv
// Approximate adder: low IMPRECISE_PART bits are filled by fixed rules, the upper
// part is an exact add fed by an OR-based carry guess.
module mheaa_adder #(
    parameter int unsigned ADDER_LENGTH   = 32,
    parameter int unsigned IMPRECISE_PART = 8
) (
    input  logic [ADDER_LENGTH-1:0] a_i,
    input  logic [ADDER_LENGTH-1:0] b_i,
    output logic [ADDER_LENGTH:0]   sum_o
);

    localparam int unsigned ExactWidth = ADDER_LENGTH - IMPRECISE_PART;

    logic                  carry;
    logic [ExactWidth:0]   exact_sum;

    assign carry     = a_i[IMPRECISE_PART-1] | b_i[IMPRECISE_PART-1];
    assign exact_sum = {1'b0, a_i[ADDER_LENGTH-1:IMPRECISE_PART]}
                     + {1'b0, b_i[ADDER_LENGTH-1:IMPRECISE_PART]}
                     + {{ExactWidth{1'b0}}, carry};

    always_comb begin
        sum_o = '0;
        for (int unsigned i = 0; i + 2 < IMPRECISE_PART; i++) begin
            sum_o[i] = 1'b1;
        end
        sum_o[IMPRECISE_PART-2]                = a_i[IMPRECISE_PART-2] | b_i[IMPRECISE_PART-2];
        sum_o[IMPRECISE_PART-1]                = 1'b0;
        sum_o[ADDER_LENGTH:IMPRECISE_PART]     = exact_sum;
    end

endmodule

// File: rtl/mheaa_accumulator.sv
// Column-output accumulator: folds a packet of unsigned products into a saturating
// running sum and presents total, beat count and overflow on a registered handshake.
module mheaa_accumulator
    import mheaa_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned IMPRECISE_PART = 8,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  acc_clr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ACC_WIDTH-1:0]  out_sum_o,
    output logic [CNT_WIDTH-1:0]  out_count_o,
    output logic                  out_ovf_o
);

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] data_ext;
    logic [ACC_WIDTH:0]   add_sum;

    assign data_ext = ACC_WIDTH'(in_data_i);

    mheaa_adder #(
        .ADDER_LENGTH   (ACC_WIDTH),
        .IMPRECISE_PART (IMPRECISE_PART)
    ) u_adder (
        .a_i   (acc_q),
        .b_i   (data_ext),
        .sum_o (add_sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready is low whenever acc_clr is high, so a valid beat alone means acceptance here.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (acc_clr_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        acc_d   = data_ext;
                        cnt_d   = CNT_WIDTH'(1);
                        ovf_d   = 1'b0;
                        state_d = in_last_i ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (in_valid_i) begin
                        if (add_sum[ACC_WIDTH] || ovf_q) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = add_sum[ACC_WIDTH-1:0];
                        end
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                        state_d = in_last_i ? StHold : StAccum;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (state_q != StHold) && !acc_clr_i;
        out_valid_o = (state_q == StHold);
        out_sum_o   = acc_q;
        out_count_o = cnt_q;
        out_ovf_o   = ovf_q;
    end

endmodule
